adc_spi_master: RTL and testbench

- Upstream serial-interface master for the 12-bit ADC receive path; produces SCLK and CS for the ADC and for the serial receiver that shifts SDATA on SCLK falling edges.
- Runs the conversion frame timing from the system clock at a fixed sample rate.
- Re-registers the receiver's 12-bit parallel result into the clk domain with a one-cycle valid strobe.

---
 rtl/adc_spi_master_if.sv | 28 ++
 rtl/adc_spi_master.sv | 195 +++++++++++++++++++
 tb/tb_adc_spi_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_master_if
// Description : Bundles the enable, receiver data and frame/result signals
//               of the ADC serial-interface master.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_spi_master_if;
    logic        en;
    logic [11:0] adc_data;
    logic        SCLK;
    logic        CS;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    modport master (
        input  en, adc_data,
        output SCLK, CS, sample, sample_valid, busy, overrun
    );

    modport slave (
        output en, adc_data,
        input  SCLK, CS, sample, sample_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/adc_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_master
// Description : Generates the periodic CS/SCLK conversion frame for a 12-bit
//               serial ADC receive path and re-registers the receiver's
//               parallel result with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_master #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int QUIET_CYCLES  = 10,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic             clk,
    input  logic             reset,
    adc_spi_master_if.master bus
);

    localparam int c_CNT_MAX  = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int c_CNT_W    = ($clog2(c_CNT_MAX) > 0) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_RATE_W   = ($clog2(SAMPLE_PERIOD) > 0) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_BIT_W    = $clog2(FRAME_BITS + 1);

    localparam logic [c_CNT_W-1:0]  c_DIV_LAST   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_QUIET_LAST = c_CNT_W'(QUIET_CYCLES - 1);
    localparam logic [c_RATE_W-1:0] c_RATE_LAST  = c_RATE_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_BIT_W-1:0]  c_BITS_LAST  = c_BIT_W'(FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_QUIET = 3'd4
    } state_t;

    state_t              state_q,   state_d;
    logic [c_CNT_W-1:0]  cnt_q,     cnt_d;
    logic [c_BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [c_RATE_W-1:0] rate_q,    rate_d;
    logic                sclk_q,    sclk_d;
    logic                cs_q,      cs_d;
    logic                busy_q,    busy_d;
    logic [11:0]         sample_q,  sample_d;
    logic                valid_q,   valid_d;
    logic                overrun_q, overrun_d;
    logic                w_tick;

    // Conversion-rate counter: parked at zero while disabled so the first
    // enabled cycle always produces a tick.
    always_comb begin
        rate_d = '0;
        if (bus.en) begin
            rate_d = (rate_q == c_RATE_LAST) ? '0 : rate_q + c_RATE_W'(1);
        end
    end

    assign w_tick = bus.en && (rate_q == '0);

    // Frame sequencer: next state plus the registered SCLK/CS/busy/result values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b1;
                cs_d   = 1'b1;
                busy_d = 1'b0;
                if (w_tick) begin
                    state_d = ST_LEAD;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            // CS low with SCLK still high: setup before the first falling edge.
            ST_LEAD: begin
                if (cnt_q == c_DIV_LAST) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    sclk_d    = 1'b0;
                    bit_cnt_d = c_BIT_W'(1);
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q == c_DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == c_BITS_LAST) begin
                        // End of the last high half: release CS, start the
                        // flush period and take the receiver's result.
                        state_d   = ST_FLUSH;
                        sclk_d    = 1'b0;
                        cs_d      = 1'b1;
                        bit_cnt_d = '0;
                        sample_d  = bus.adc_data;
                        valid_d   = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            // One full SCLK period with CS high returns the receiver to CS-detect.
            ST_FLUSH: begin
                if (cnt_q == c_DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        state_d = ST_QUIET;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            ST_QUIET: begin
                if (cnt_q == c_QUIET_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sclk_d  = 1'b1;
                cs_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A tick that finds a frame in progress is lost, not queued.
        if (w_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            rate_q    <= '0;
            sclk_q    <= 1'b1;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            rate_q    <= rate_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.SCLK         = sclk_q;
    assign bus.CS           = cs_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_spi_master
// Description : Self-checking bench for adc_spi_master with a behavioural
//               ADC/receiver model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_master;

    localparam int SP = 2000;

    typedef struct {
        logic [11:0] val;
        int          due;
    } exp_t;

    typedef struct {
        logic [15:0] frame;
        logic [11:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   ncyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        sb[$];
    int          fall_q[$];
    logic [15:0] frame_word = 16'h0000;
    logic        aborted = 1'b0;

    adc_spi_master_if bus();
    adc_spi_master_if bus2();

    adc_spi_master #(
        .CLK_DIV(4), .FRAME_BITS(16), .QUIET_CYCLES(10), .SAMPLE_PERIOD(SP)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    adc_spi_master #(
        .CLK_DIV(4), .FRAME_BITS(16), .QUIET_CYCLES(10), .SAMPLE_PERIOD(100)
    ) u_ovr (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic wait_sb_empty(input int limit, input string name);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    // Receiver model plus frame/scoreboard monitor for the main DUT.
    initial begin
        logic        prev_cs, prev_sclk, prev_busy;
        logic [15:0] rx_sh;
        int          rx_cnt, low_cnt, nfl, nfh, busy_cnt;
        exp_t        e;
        bus.adc_data = '0;
        rx_sh = '0; rx_cnt = 0; low_cnt = 0; nfl = 0; nfh = 0; busy_cnt = 0;
        @(negedge clk);
        prev_cs = 1'b1; prev_sclk = 1'b1; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_cnt = 0;
                bus.adc_data = '0;
            end else begin
                if (prev_cs && !bus.CS) rx_cnt = 0;
                if (prev_sclk && !bus.SCLK && !bus.CS && rx_cnt < 16) begin
                    rx_sh = {rx_sh[14:0], frame_word[15 - rx_cnt]};
                    rx_cnt++;
                    if (rx_cnt == 16) bus.adc_data = rx_sh[11:0];
                end
            end

            if (prev_cs && !bus.CS) begin
                fall_q.push_back(ncyc);
                low_cnt = 0;
                nfl = 0;
                aborted = 1'b0;
            end
            if (!bus.CS) low_cnt++;
            if (!prev_cs && bus.CS && !aborted) begin
                check("cs_low_cycles", low_cnt, 132);
                check("sclk_falls_cs_low", nfl, 16);
            end
            if (!prev_cs && bus.CS) nfh = 0;
            if (prev_sclk && !bus.SCLK) begin
                if (!bus.CS) nfl++;
                else nfh++;
            end

            if (!prev_busy && bus.busy) busy_cnt = 0;
            if (bus.busy) busy_cnt++;
            if (prev_busy && !bus.busy && !aborted) begin
                check("busy_cycles", busy_cnt, 150);
                check("sclk_falls_cs_high", nfh, 1);
            end

            if (bus.sample_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got sample_valid=1 sample=%0h expected no pulse (cycle %0d)",
                             bus.sample, ncyc);
                end else begin
                    e = sb.pop_front();
                    check("sample", 32'(bus.sample), 32'(e.val));
                    check("valid_cycle", ncyc, e.due);
                end
            end

            prev_cs   = bus.CS;
            prev_sclk = bus.SCLK;
            prev_busy = bus.busy;
        end
    end

    // Stimulus and hand-written sequences.
    initial begin
        vec_t vec[4];
        int   en_cyc, c0, c;
        int   f2[$];
        logic prev2;

        vec[0] = '{16'h0ABC, 12'hABC};
        vec[1] = '{16'h0123, 12'h123};
        vec[2] = '{16'h0FFF, 12'hFFF};
        vec[3] = '{16'h0000, 12'h000};

        reset = 1'b1;
        reset2 = 1'b1;
        bus.en = 1'b1;
        bus2.en = 1'b0;
        bus2.adc_data = 12'h3C3;

        // Reset with en high: everything idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", 32'({bus.SCLK, bus.CS, bus.sample, bus.sample_valid, bus.busy, bus.overrun}),
                  32'({1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0}));
        end

        // Overrun sequence on the short-period instance.
        reset2 = 1'b0;
        @(negedge clk);
        bus2.en = 1'b1;
        c0 = ncyc;
        prev2 = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (prev2 && !bus2.CS) f2.push_back(ncyc);
            prev2 = bus2.CS;
            if (ncyc == c0 + 100) check("ovr_before_tick", 32'(bus2.overrun), 0);
            if (ncyc == c0 + 101) check("ovr_after_tick", 32'(bus2.overrun), 1);
            if (ncyc == c0 + 150) check("ovr_busy_last", 32'(bus2.busy), 1);
            if (ncyc == c0 + 151) check("ovr_busy_drop", 32'(bus2.busy), 0);
        end
        bus2.en = 1'b0;
        check("ovr_sticky", 32'(bus2.overrun), 1);
        check("ovr_frame_count", f2.size(), 2);
        if (f2.size() >= 2) begin
            check("ovr_fall0", f2[0], c0 + 1);
            check("ovr_fall1", f2[1], c0 + 201);
        end
        check("main_idle_in_reset", 32'({bus.CS, bus.busy}), 32'(2'b10));

        // Table-driven frames: en already high as reset releases.
        frame_word = vec[0].frame;
        en_cyc = ncyc;
        sb.push_back('{vec[0].exp, en_cyc + 133});
        reset = 1'b0;
        wait_sb_empty(3000, "frame0_timeout");
        for (int i = 1; i < 4; i++) begin
            frame_word = vec[i].frame;
            sb.push_back('{vec[i].exp, en_cyc + i * SP + 133});
            wait_sb_empty(3000, "frame_timeout");
        end
        check("periodic_frames", fall_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < fall_q.size()) check("cs_fall_cycle", fall_q[i], en_cyc + 1 + i * SP);
        end
        check("periodic_overrun", 32'(bus.overrun), 0);

        // en dropped mid-frame: frame completes, nothing follows.
        frame_word = 16'h0C3C;
        sb.push_back('{12'hC3C, en_cyc + 4 * SP + 133});
        for (int k = 0; k < 2500 && fall_q.size() < 5; k++) @(negedge clk);
        check("endrop_frame_start", fall_q.size(), 5);
        repeat (50) @(negedge clk);
        bus.en = 1'b0;
        wait_sb_empty(300, "endrop_timeout");
        repeat (2100) @(negedge clk);
        check("endrop_no_more_frames", fall_q.size(), 5);
        check("endrop_sample_held", 32'(bus.sample), 32'h0C3C);

        // Reset mid-frame, started by a one-cycle en pulse.
        frame_word = 16'h0777;
        @(negedge clk);
        bus.en = 1'b1;
        c = ncyc;
        @(negedge clk);
        bus.en = 1'b0;
        while (ncyc < c + 61) @(negedge clk);
        check("midreset_in_frame", 32'({bus.CS, bus.busy}), 32'(2'b01));
        aborted = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", 32'({bus.SCLK, bus.CS, bus.busy, bus.sample_valid, bus.overrun}),
              32'(5'b11000));
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("midreset_idle", 32'({bus.CS, bus.busy}), 32'(2'b10));

        // Next frame after reset, single-cycle en pulse.
        frame_word = 16'h05A5;
        bus.en = 1'b1;
        c = ncyc;
        sb.push_back('{12'h5A5, c + 133});
        @(negedge clk);
        bus.en = 1'b0;
        wait_sb_empty(300, "post_reset_timeout");
        check("post_reset_sample", 32'(bus.sample), 32'h5A5);
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
